// File: rtl/vc_reset_ctrl.sv
// Reset and run-enable controller for the vc CPU tile: synchronised reset release,
// ena-qualified reset stretch, staggered per-domain release and halt/single-step gating.
module vc_reset_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int NUM_DOMAINS = 2,
    parameter int STAGGER     = 4,
    parameter int STEP_CW     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   soft_reset,
    input  logic                   halt_req,
    input  logic                   step_mode,
    input  logic                   step_req,
    output logic [NUM_DOMAINS-1:0] core_reset,
    output logic                   run_ena,
    output logic                   ready,
    output logic [STEP_CW-1:0]     step_count
);

    localparam int SCNT_W  = $clog2(STRETCH + 1);
    localparam int REL_MAX = (NUM_DOMAINS - 1) * STAGGER;
    localparam int RCNT_W  = $clog2(REL_MAX + 2);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STRETCH - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REL_MAX);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rst_sync_s;
    state_t                 state_r, state_s;
    logic [SCNT_W-1:0]      scnt_r, scnt_s;
    logic [RCNT_W-1:0]      rcnt_r, rcnt_s, rcnt_inc_s;
    logic [NUM_DOMAINS-1:0] core_reset_r, core_reset_s;
    logic                   run_ena_r, run_ena_s;
    logic                   ready_r, ready_s;
    logic [STEP_CW-1:0]     step_count_r, step_count_s;
    logic                   step_prev_r;
    logic                   step_rise_s;
    logic                   abort_s;

    // Reset-release synchroniser: asserts asynchronously, releases after SYNC_STAGES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_s  = sync_r[SYNC_STAGES-1];
    assign abort_s     = (~ena) | soft_reset;
    assign step_rise_s = step_req & ~step_prev_r;
    assign rcnt_inc_s  = rcnt_r + RCNT_W'(1);

    // Next-state and next-output logic for the reset sequence and run gating
    always_comb begin
        state_s      = state_r;
        scnt_s       = scnt_r;
        rcnt_s       = rcnt_r;
        core_reset_s = core_reset_r;
        run_ena_s    = 1'b0;
        ready_s      = ready_r;
        step_count_s = step_count_r;

        if ((state_r != ST_RESET) && abort_s) begin
            // An abort restarts the stretch from zero but keeps the step history
            state_s      = ST_STRETCH;
            scnt_s       = {SCNT_W{1'b0}};
            rcnt_s       = {RCNT_W{1'b0}};
            core_reset_s = {NUM_DOMAINS{1'b1}};
            ready_s      = 1'b0;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (rst_sync_s) begin
                        state_s = ST_STRETCH;
                        scnt_s  = {SCNT_W{1'b0}};
                    end else begin
                        state_s = ST_RESET;
                    end
                end
                ST_STRETCH: begin
                    if (scnt_r == SCNT_LAST) begin
                        core_reset_s[0] = 1'b0;
                        rcnt_s          = {RCNT_W{1'b0}};
                        if (NUM_DOMAINS == 1) begin
                            state_s = ST_RUN;
                            ready_s = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        scnt_s = scnt_r + SCNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    rcnt_s = rcnt_inc_s;
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (rcnt_inc_s == RCNT_W'(i * STAGGER)) begin
                            core_reset_s[i] = 1'b0;
                        end else begin
                            core_reset_s[i] = core_reset_r[i];
                        end
                    end
                    if (rcnt_inc_s == RCNT_LAST) begin
                        state_s = ST_RUN;
                        ready_s = 1'b1;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                ST_RUN: begin
                    // Halt wins; in step mode only a fresh step_req edge opens one cycle
                    if (halt_req) begin
                        run_ena_s = 1'b0;
                    end else if (step_mode) begin
                        run_ena_s    = step_rise_s;
                        step_count_s = step_count_r + STEP_CW'(step_rise_s);
                    end else begin
                        run_ena_s = 1'b1;
                    end
                end
                default: begin
                    state_s      = ST_RESET;
                    core_reset_s = {NUM_DOMAINS{1'b1}};
                    ready_s      = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; rst_n clears everything without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RESET;
            scnt_r       <= {SCNT_W{1'b0}};
            rcnt_r       <= {RCNT_W{1'b0}};
            core_reset_r <= {NUM_DOMAINS{1'b1}};
            run_ena_r    <= 1'b0;
            ready_r      <= 1'b0;
            step_count_r <= {STEP_CW{1'b0}};
            step_prev_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            scnt_r       <= scnt_s;
            rcnt_r       <= rcnt_s;
            core_reset_r <= core_reset_s;
            run_ena_r    <= run_ena_s;
            ready_r      <= ready_s;
            step_count_r <= step_count_s;
            step_prev_r  <= step_req;
        end
    end

    assign core_reset = core_reset_r;
    assign run_ena    = run_ena_r;
    assign ready      = ready_r;
    assign step_count = step_count_r;

endmodule

// File: tb/tb_vc_reset_ctrl.sv
// Self-checking bench for vc_reset_ctrl: directed table and sequences plus randomized
// stimulus compared every cycle against a behavioural model, on two parameter sets.
module tb_vc_reset_ctrl;

    logic clk = 1'b0;
    logic rst_n, ena, soft_reset, halt_req, step_mode, step_req;
    logic [1:0] core_reset;
    logic       run_ena, ready;
    logic [7:0] step_count;
    logic [2:0] core_reset2;
    logic       run_ena2, ready2;
    logic [1:0] step_count2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int re_cnt = 0;

    vc_reset_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .soft_reset(soft_reset),
        .halt_req(halt_req), .step_mode(step_mode), .step_req(step_req),
        .core_reset(core_reset), .run_ena(run_ena), .ready(ready), .step_count(step_count)
    );

    vc_reset_ctrl #(
        .SYNC_STAGES(3), .STRETCH(3), .NUM_DOMAINS(3), .STAGGER(2), .STEP_CW(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .soft_reset(soft_reset),
        .halt_req(halt_req), .step_mode(step_mode), .step_req(step_req),
        .core_reset(core_reset2), .run_ena(run_ena2), .ready(ready2), .step_count(step_count2)
    );

    always #5 clk = ~clk;

    // Behavioural model: counts consecutive qualified ena cycles, then tracks the age
    // since the first domain was released; all outputs derive from those numbers.
    typedef struct {
        int sync;
        bit started;
        int cnt;
        int age;
        bit prev;
        bit run;
        int steps;
    } mstate_t;

    mstate_t m1, m2;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.sync = 0; s.started = 1'b0; s.cnt = 0; s.age = -1;
        s.prev = 1'b0; s.run = 1'b0; s.steps = 0;
        return s;
    endfunction

    function automatic mstate_t m_next(mstate_t s, int ss, int st, int nd, int stg, int cw,
                                       logic e, logic sr, logic h, logic sm, logic rq);
        mstate_t n = s;
        bit rise = rq && !s.prev;
        int rmax = (nd - 1) * stg;
        n.prev = rq;
        n.run  = 1'b0;
        if (!s.started) begin
            if (s.sync >= ss) begin
                n.started = 1'b1;
                n.cnt = 0;
            end
            n.sync = s.sync + 1;
        end else if (!e || sr) begin
            n.cnt = 0;
            n.age = -1;
        end else if (s.age < 0) begin
            n.cnt = s.cnt + 1;
            if (n.cnt == st) n.age = 0;
        end else if (s.age >= rmax) begin
            if (!h) begin
                if (!sm) n.run = 1'b1;
                else if (rise) begin
                    n.run = 1'b1;
                    n.steps = (s.steps + 1) % (1 << cw);
                end
            end
        end else begin
            n.age = s.age + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] m_core(mstate_t s, int nd, int stg);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < nd; i++) r[i] = !(s.age >= i * stg);
        return r;
    endfunction

    function automatic logic m_ready(mstate_t s, int nd, int stg);
        return s.age >= (nd - 1) * stg;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 = m_reset();
            m2 = m_reset();
        end else begin
            m1 = m_next(m1, 2, 16, 2, 4, 8, ena, soft_reset, halt_req, step_mode, step_req);
            m2 = m_next(m2, 3, 3, 3, 2, 2, ena, soft_reset, halt_req, step_mode, step_req);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (chk_en) begin
            chk("m1 core_reset", 32'(core_reset), 32'(m_core(m1, 2, 4)));
            chk("m1 ready", 32'(ready), 32'(m_ready(m1, 2, 4)));
            chk("m1 run_ena", 32'(run_ena), 32'(m1.run));
            chk("m1 step_count", 32'(step_count), m1.steps);
            chk("m2 core_reset", 32'(core_reset2), 32'(m_core(m2, 3, 2)));
            chk("m2 ready", 32'(ready2), 32'(m_ready(m2, 3, 2)));
            chk("m2 run_ena", 32'(run_ena2), 32'(m2.run));
            chk("m2 step_count", 32'(step_count2), m2.steps);
        end
        if (run_ena === 1'b1) re_cnt++;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        step_req = 1'b1;
        step(hi);
        step_req = 1'b0;
        step(lo);
    endtask

    typedef struct {
        int         edge_n;
        logic       ena_v;
        logic [1:0] core;
        logic       rdy;
        logic       run;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   wrap_exp[5];
        int   cur, n, m, rst_hold;

        tbl[0] = '{1,  1'b1, 2'b11, 1'b0, 1'b0};
        tbl[1] = '{18, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[2] = '{19, 1'b1, 2'b10, 1'b0, 1'b0};
        tbl[3] = '{22, 1'b1, 2'b10, 1'b0, 1'b0};
        tbl[4] = '{23, 1'b1, 2'b00, 1'b1, 1'b0};
        tbl[5] = '{24, 1'b1, 2'b00, 1'b1, 1'b1};
        wrap_exp = '{1, 2, 3, 0, 1};

        m1 = m_reset();
        m2 = m_reset();
        rst_n = 1'b0; ena = 1'b1; soft_reset = 1'b0;
        halt_req = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        step(2);
        chk("reset core_reset", 32'(core_reset), 32'h3);
        chk("reset core_reset2", 32'(core_reset2), 32'h7);
        chk("reset run_ena", 32'(run_ena), 32'h0);
        chk("reset ready", 32'(ready), 32'h0);
        chk("reset step_count", 32'(step_count), 32'h0);
        chk_en = 1'b1;

        // Power-up sequence with ena held high
        rst_n = 1'b1;
        cur = 0;
        for (int i = 0; i < 6; i++) begin
            ena = tbl[i].ena_v;
            step(tbl[i].edge_n - cur);
            cur = tbl[i].edge_n;
            chk($sformatf("pwr core e%0d", cur), 32'(core_reset), 32'(tbl[i].core));
            chk($sformatf("pwr ready e%0d", cur), 32'(ready), 32'(tbl[i].rdy));
            chk($sformatf("pwr run e%0d", cur), 32'(run_ena), 32'(tbl[i].run));
        end
        step(3);

        // Single-step: three rises, one held for five cycles
        step_mode = 1'b1;
        step(1);
        chk("mode drop run_ena", 32'(run_ena), 32'h0);
        re_cnt = 0;
        pulse(1, 2);
        pulse(5, 2);
        pulse(1, 2);
        chk("step pulses", re_cnt, 3);
        chk("step count 3", 32'(step_count), 32'd3);

        // Halt discards step requests and does not queue them
        halt_req = 1'b1;
        step(1);
        re_cnt = 0;
        pulse(1, 2);
        pulse(1, 2);
        chk("halt count kept", 32'(step_count), 32'd3);
        chk("halt no pulses", re_cnt, 0);
        halt_req = 1'b0;
        step(3);
        chk("unhalt no pulse", re_cnt, 0);
        chk("unhalt run_ena", 32'(run_ena), 32'h0);
        pulse(1, 2);
        chk("fresh step pulse", re_cnt, 1);
        chk("step count 4", 32'(step_count), 32'd4);
        step_mode = 1'b0;
        step(1);
        chk("mode rise run_ena", 32'(run_ena), 32'h1);

        // Soft reset in RUN restarts the sequence, step count preserved
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        chk("soft core_reset", 32'(core_reset), 32'h3);
        chk("soft run_ena", 32'(run_ena), 32'h0);
        chk("soft ready", 32'(ready), 32'h0);
        chk("soft step_count", 32'(step_count), 32'd4);
        n = 0;
        while (core_reset[0] !== 1'b0 && n < 60) begin step(1); n++; end
        chk("soft rel0 edges", n, 16);
        m = 0;
        while (ready !== 1'b1 && m < 60) begin step(1); m++; end
        chk("soft ready edges", m, 4);

        // Asynchronous rst_n in the middle of RELEASE
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        step(18);
        chk("midrel core_reset", 32'(core_reset), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("async core_reset", 32'(core_reset), 32'h3);
        chk("async step_count", 32'(step_count), 32'h0);
        chk("async ready", 32'(ready), 32'h0);
        chk("async core_reset2", 32'(core_reset2), 32'h7);
        step(3);

        // Step counter wrap on the STEP_CW=2 instance
        rst_n = 1'b1;
        n = 0;
        while ((ready !== 1'b1 || ready2 !== 1'b1) && n < 100) begin step(1); n++; end
        chk("repower ready edges", n, 23);
        step_mode = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            pulse(1, 2);
            chk($sformatf("wrap step %0d", i), 32'(step_count2), wrap_exp[i]);
        end
        chk("wide step count 5", 32'(step_count), 32'd5);
        step_mode = 1'b0;

        // One-cycle ena drop during STRETCH restarts the count
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(9);
        ena = 1'b0;
        step(1);
        ena = 1'b1;
        n = 0;
        while (core_reset[0] !== 1'b0 && n < 60) begin step(1); n++; end
        chk("glitch rel0 edge", 10 + n, 26);
        m = 0;
        while (core_reset[1] !== 1'b0 && m < 60) begin step(1); m++; end
        chk("glitch rel1 gap", m, 4);

        // Randomized traffic against the model
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            ena        = ($urandom_range(0, 99) < 96);
            soft_reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 29) == 0) step_mode = ~step_mode;
            step_req   = ($urandom_range(0, 2) == 0);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                rst_hold = $urandom_range(1, 3);
            end
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_reset_ctrl.md
Name: vc_reset_ctrl

Overview:
Parametrised reset and run-enable controller for the vc CPU top level. It replaces the single-flop reset capture with a full sequence:
- synchronises release of the asynchronous reset;
- debounces the tile enable;
- stretches reset;
- releases up to NUM_DOMAINS core reset domains in staggered order;
- gates core execution with halt and single-step control.

It sits between the tile pins (clk, rst_n, ena, debug inputs) and the CPU and peripheral reset/enable inputs.

Parameters:
SYNC_STAGES, 2, number of reset-release synchroniser flops (min 2)
STRETCH, 16, consecutive ena-high cycles required before first domain release (min 1)
NUM_DOMAINS, 2, number of independently released core reset outputs (1..8)
STAGGER, 4, cycles between release of domain i and domain i+1 (min 1)
STEP_CW, 8, width of the single-step counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; low forces the core back into reset
soft_reset  input  1  synchronous pulse; restarts the reset sequence
halt_req  input  1  level; holds run_ena low while in RUN
step_mode  input  1  level; selects single-step execution
step_req  input  1  synchronous; each rising edge grants one run cycle in step mode
core_reset  output  NUM_DOMAINS  active-high reset per domain; bit 0 released first
run_ena  output  1  core clock-enable / execute strobe
ready  output  1  high while state is RUN
step_count  output  STEP_CW  number of step pulses issued, wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- rst_n low, asserted asynchronously:
  - synchroniser chain cleared;
  - state=RESET;
  - core_reset all 1; run_ena=0; ready=0;
  - step_count=0; counters=0; step_req edge register=0.
- Deassertion: rst_n release propagates through SYNC_STAGES flops to rst_sync. No other logic reads rst_n except the async clears.
- States: RESET, STRETCH, RELEASE, RUN.
- RESET -> STRETCH on the first edge where rst_sync=1. Stretch counter=0.
- STRETCH:
  - the counter increments each cycle ena=1 and clears to 0 each cycle ena=0;
  - when the counter equals STRETCH-1 with ena=1, go to RELEASE, or directly to RUN if NUM_DOMAINS=1;
  - core_reset[0] clears on that same edge.
- Timing: with ena held high, core_reset[0] falls on rising edge SYNC_STAGES+STRETCH+1 after rst_n deasserts. Defaults: edge 19.
- RELEASE:
  - the release counter starts at 0 and increments each cycle;
  - core_reset[i] clears on the edge where the counter reaches i*STAGGER;
  - on the edge clearing core_reset[NUM_DOMAINS-1], the state goes to RUN and ready=1 on that same edge.
  - Defaults: core_reset[1] falls at edge 23.
- Already-released domains stay released during RELEASE. core_reset is only ever cleared in ascending index order.
- Abort (ena=0 or soft_reset=1 in any state other than RESET):
  - on the next edge, state=STRETCH with counter=0;
  - all core_reset=1; run_ena=0; ready=0;
  - step_count is preserved.
  - Both conditions together behave identically to either one alone.
- run_ena is registered and is 0 outside RUN. In RUN, in priority order:
  - halt_req=1 -> 0;
  - step_mode=1 -> 1 for exactly one cycle on the edge after a step_req rising edge (step_req sampled against its previous registered value); step_count increments on that same edge;
  - otherwise -> 1.
- Step requests arriving while halted, or outside RUN, are discarded and not queued. The edge register still tracks step_req.
- Mode changes: switching step_mode 0->1 mid-run drops run_ena on the next edge. Switching 1->0 raises it on the next edge.
- step_count wraps from 2^STEP_CW-1 to 0.
- rst_n assertion mid-sequence overrides everything immediately, without waiting for a clock edge.

Test Plan:
- Defaults, rst_n rises at edge 0, ena=1 throughout -> core_reset=2'b11 until edge 19; 2'b10 at edge 19; 2'b00 and ready=1 at edge 23; run_ena=1 at edge 24.
- ena low for 1 cycle at edge 10 during STRETCH -> counter restarts; core_reset[0] falls 16 edges after ena returns high; core_reset[1] 4 edges later.
- In RUN, soft_reset pulse -> next edge core_reset=2'b11, run_ena=0, ready=0, step_count unchanged; release repeats after 16+4 cycles.
- step_mode=1, three step_req rising edges spaced 3 cycles apart (one held high for 5 cycles) -> exactly three 1-cycle run_ena pulses, one edge after each rise; step_count=3.
- halt_req=1 in RUN with step_mode=1, two step_req pulses -> run_ena stays 0, step_count unchanged; after halt_req=0, run_ena stays 0 until a fresh step_req edge.
- STEP_CW=2, issue 5 steps -> step_count sequence 1,2,3,0,1. Asserting rst_n low mid-RELEASE forces core_reset all 1 and step_count 0 before the next clock edge.
